// File: rtl/id_pkg.sv
// Shared encodings for the instruction-decode stage: ARM opcode/mode fields,
// execute commands, condition codes, status-flag positions and the ID/EXE control bundle.
package id_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic        imm;
    logic [3:0]  exe_cmd;
    logic [11:0] shift_op;
    logic [23:0] imm24;
  } id_ctl_t;

  // NV (1111) is deliberately a never-execute code here.
  function automatic logic cond_pass(input cond_e cond, input logic [3:0] sr);
    logic n, z, c, v;
    n = sr[FLAG_N];
    z = sr[FLAG_Z];
    c = sr[FLAG_C];
    v = sr[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: reset-to-index contents, one write port,
// two combinational read ports; ID_WB_BYPASS_EN forwards a same-cycle write to the reads.
module id_regfile
  import id_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rd_idx1,
  input  logic [RA_W-1:0]   rd_idx2,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rd_data1 = (wr_en && (wr_idx == rd_idx1)) ? wr_data : regs[rd_idx1];
  assign rd_data2 = (wr_en && (wr_idx == rd_idx2)) ? wr_data : regs[rd_idx2];
`else
  // Without forwarding a same-cycle write is seen only on the following cycle.
  assign rd_data1 = regs[rd_idx1];
  assign rd_data2 = regs[rd_idx2];
`endif

endmodule

// File: rtl/id_decode_pipe.sv
// ARM instruction decode with condition check and ID/EXE register, valid/ready handshake,
// hazard stall and branch flush. Optional write-back forwarding: ID_WB_BYPASS_EN.
module id_decode_pipe
  import id_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [3:0]        SR,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [RA_W-1:0]   id_src1,
  output logic [RA_W-1:0]   id_src2,
  output logic              id_two_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_En,
  output logic              Mem_R_En,
  output logic              Mem_W_En,
  output logic              B,
  output logic              S,
  output logic              Imm,
  output logic [3:0]        Exe_CMD,
  output logic [RA_W-1:0]   Dest,
  output logic [11:0]       Shift_Operand,
  output logic [23:0]       Sign_Imm_24,
  output logic [DATA_W-1:0] Value_Rn,
  output logic [DATA_W-1:0] Value_Rm
);

  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic              is_store;
  logic              cond_ok;
  logic              advance;
  logic              take;
  id_ctl_t           dec_ctl;
  logic [DATA_W-1:0] rn_p0, rm_p0;

  logic              vld_p1;
  id_ctl_t           ctl_p1;
  logic [RA_W-1:0]   dest_p1;
  logic [DATA_W-1:0] rn_p1, rm_p1;

  // ---- stage 0: decode, condition check, operand read ----
  assign mode     = instruction[27:26];
  assign opcode   = instruction[24:21];
  assign is_store = (mode == MODE_MEM) && !instruction[20];
  assign cond_ok  = cond_pass(cond_e'(instruction[31:28]), SR);

  // Store data comes from Rd, so the second read port follows Rd for stores.
  assign id_src1    = RA_W'(instruction[19:16]);
  assign id_src2    = is_store ? RA_W'(instruction[15:12]) : RA_W'(instruction[3:0]);
  assign id_two_src = is_store | ~instruction[25];

  always_comb begin
    dec_ctl          = '0;
    dec_ctl.shift_op = instruction[11:0];
    dec_ctl.imm24    = instruction[23:0];
    case (mode)
      MODE_DP: begin
        dec_ctl.wb_en = 1'b1;
        case (opcode)
          OP_MOV:  dec_ctl.exe_cmd = EXE_MOV;
          OP_MVN:  dec_ctl.exe_cmd = EXE_MVN;
          OP_ADD:  dec_ctl.exe_cmd = EXE_ADD;
          OP_ADC:  dec_ctl.exe_cmd = EXE_ADC;
          OP_SUB:  dec_ctl.exe_cmd = EXE_SUB;
          OP_SBC:  dec_ctl.exe_cmd = EXE_SBC;
          OP_AND:  dec_ctl.exe_cmd = EXE_AND;
          OP_ORR:  dec_ctl.exe_cmd = EXE_ORR;
          OP_EOR:  dec_ctl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            dec_ctl.exe_cmd = EXE_SUB;
            dec_ctl.wb_en   = 1'b0;
          end
          OP_TST: begin
            dec_ctl.exe_cmd = EXE_AND;
            dec_ctl.wb_en   = 1'b0;
          end
          default: dec_ctl.wb_en = 1'b0;
        endcase
        if (dec_ctl.exe_cmd != EXE_NOP) begin
          dec_ctl.s   = instruction[20];
          dec_ctl.imm = instruction[25];
        end
      end
      MODE_MEM: begin
        dec_ctl.exe_cmd  = EXE_ADD;
        dec_ctl.imm      = instruction[25];
        dec_ctl.wb_en    = instruction[20];
        dec_ctl.mem_r_en = instruction[20];
        dec_ctl.mem_w_en = ~instruction[20];
      end
      MODE_BR: dec_ctl.b = 1'b1;
      default: ;
    endcase
  end

  id_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_idx1 (id_src1),
    .rd_idx2 (id_src2),
    .wr_en   (wb_en),
    .wr_idx  (wb_dest),
    .wr_data (wb_value),
    .rd_data1(rn_p0),
    .rd_data2(rm_p0)
  );

  // ---- stage 1: ID/EXE register ----
  assign advance  = out_ready | ~vld_p1;
  assign in_ready = (~hazard & advance) | flush;
  assign take     = ~hazard & in_valid & cond_ok;

  // Anything that frees the register without a passing instruction leaves a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      ctl_p1  <= '0;
      dest_p1 <= '0;
      rn_p1   <= '0;
      rm_p1   <= '0;
    end else if (flush || (advance && !take)) begin
      vld_p1  <= 1'b0;
      ctl_p1  <= '0;
      dest_p1 <= '0;
      rn_p1   <= '0;
      rm_p1   <= '0;
    end else if (advance) begin
      vld_p1  <= 1'b1;
      ctl_p1  <= dec_ctl;
      dest_p1 <= RA_W'(instruction[15:12]);
      rn_p1   <= rn_p0;
      rm_p1   <= rm_p0;
    end
  end

  assign out_valid     = vld_p1;
  assign WB_En         = ctl_p1.wb_en;
  assign Mem_R_En      = ctl_p1.mem_r_en;
  assign Mem_W_En      = ctl_p1.mem_w_en;
  assign B             = ctl_p1.b;
  assign S             = ctl_p1.s;
  assign Imm           = ctl_p1.imm;
  assign Exe_CMD       = ctl_p1.exe_cmd;
  assign Shift_Operand = ctl_p1.shift_op;
  assign Sign_Imm_24   = ctl_p1.imm24;
  assign Dest          = dest_p1;
  assign Value_Rn      = rn_p1;
  assign Value_Rm      = rm_p1;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Scoreboard bench for id_decode_pipe: expected records are queued when an instruction
// is issued and compared whenever the DUT completes an output handshake.
module tb_id_decode_pipe;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int RA_W     = 4;

  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] I_SUBEQ = 32'h00421003; // SUBEQ R1,R2,R3
  localparam logic [31:0] I_SUBNV = 32'hF0821003; // ADD with cond 1111
  localparam logic [31:0] I_MOV   = 32'hE1A04006; // MOV R4,R6
  localparam logic [31:0] I_EOR   = 32'hE0285009; // EOR R5,R8,R9

  logic              clk;
  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       instruction;
  logic [3:0]        SR;
  logic              hazard, flush;
  logic              wb_en;
  logic [RA_W-1:0]   wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [RA_W-1:0]   id_src1, id_src2;
  logic              id_two_src;
  logic              out_valid, out_ready;
  logic              WB_En, Mem_R_En, Mem_W_En, B, S, Imm;
  logic [3:0]        Exe_CMD;
  logic [RA_W-1:0]   Dest;
  logic [11:0]       Shift_Operand;
  logic [23:0]       Sign_Imm_24;
  logic [DATA_W-1:0] Value_Rn, Value_Rm;

  id_decode_pipe #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .SR(SR), .hazard(hazard), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_En(WB_En), .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En), .B(B), .S(S), .Imm(Imm),
    .Exe_CMD(Exe_CMD), .Dest(Dest), .Shift_Operand(Shift_Operand),
    .Sign_Imm_24(Sign_Imm_24), .Value_Rn(Value_Rn), .Value_Rm(Value_Rm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s;
    logic [3:0]  dest;
    logic [31:0] rn, rm;
    logic [11:0] sh;
    logic [23:0] imm24;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [3:0] cmd,
                      input logic wb, input logic mr, input logic mw, input logic b,
                      input logic s, input logic [3:0] dest,
                      input logic [31:0] rn, input logic [31:0] rm);
    exp_t x;
    x.cmd = cmd; x.wb = wb; x.mr = mr; x.mw = mw; x.b = b; x.s = s;
    x.dest = dest; x.rn = rn; x.rm = rm;
    x.sh = ins[11:0];
    x.imm24 = ins[23:0];
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      check("sb_pending", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        pops++;
        check("exe_cmd", Exe_CMD, e.cmd);
        check("wb_en", WB_En, e.wb);
        check("mem_r", Mem_R_En, e.mr);
        check("mem_w", Mem_W_En, e.mw);
        check("b", B, e.b);
        check("s", S, e.s);
        check("dest", Dest, e.dest);
        check("value_rn", Value_Rn, e.rn);
        check("value_rm", Value_Rm, e.rm);
        check("shift_op", Shift_Operand, e.sh);
        check("imm24", Sign_Imm_24, e.imm24);
      end
    end
  end

  // Back-to-back stream: MVNS R4,R6 / CMP R2,R3 / LDR R1,[R2,#4] / STR R3,[R2,#4] / B .
  logic [31:0] st_ins  [5] = '{32'hE1F04006, 32'hE1520003, 32'hE5921004, 32'hE5823004, 32'hEAFFFFFE};
  logic [3:0]  st_cmd  [5] = '{4'h9, 4'h4, 4'h2, 4'h2, 4'h0};
  logic        st_wb   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        st_mr   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        st_mw   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        st_b    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        st_s    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0]  st_dest [5] = '{4'd4, 4'd0, 4'd1, 4'd3, 4'd15};
  logic [31:0] st_rn   [5] = '{32'd0, 32'd2, 32'd2, 32'd2, 32'd15};
  logic [31:0] st_rm   [5] = '{32'd6, 32'd3, 32'd4, 32'd3, 32'd14};
  logic [3:0]  st_src2 [5] = '{4'd6, 4'd3, 4'd4, 4'd3, 4'd14};
  logic        st_two  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int p0;

  initial begin
    rst = 1'b0; in_valid = 1'b0; instruction = '0; SR = '0; hazard = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_cmd", Exe_CMD, 4'h0);
    check("rst_wb", WB_En, 1'b0);
    check("rst_dest", Dest, 4'h0);
    check("rst_rn", Value_Rn, 32'h0);
    check("rst_rm", Value_Rm, 32'h0);
    rst = 1'b1;
    tick();

    // Basic ADD with one-cycle latency
    instruction = I_ADD; in_valid = 1'b1;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
    #1 check("add_in_ready", in_ready, 1'b1);
    check("add_src1", id_src1, 4'd2);
    tick();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1'b1);
    check("add_cmd", Exe_CMD, 4'h2);
    tick();

    // Full-rate stream across data-processing, memory and branch classes
    for (int i = 0; i < 5; i++) begin
      instruction = st_ins[i]; in_valid = 1'b1;
      push(st_ins[i], st_cmd[i], st_wb[i], st_mr[i], st_mw[i], st_b[i], st_s[i],
           st_dest[i], st_rn[i], st_rm[i]);
      #1 check("st_src2", id_src2, st_src2[i]);
      check("st_two_src", id_two_src, st_two[i]);
      check("st_in_ready", in_ready, 1'b1);
      tick();
      check("st_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("st_drain", out_valid, 1'b0);

    // Conditional execution: EQ with Z clear, then set; NV always fails
    instruction = I_SUBEQ; in_valid = 1'b1; SR = 4'b0000;
    #1 check("eq_in_ready", in_ready, 1'b1);
    tick();
    check("eq_fail_valid", out_valid, 1'b0);
    check("eq_fail_cmd", Exe_CMD, 4'h0);
    SR = 4'b0100;
    push(I_SUBEQ, 4'h4, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
    tick();
    check("eq_pass_cmd", Exe_CMD, 4'h4);
    instruction = I_SUBNV;
    tick();
    check("nv_valid", out_valid, 1'b0);
    in_valid = 1'b0; SR = 4'b0000;
    tick();

    // Hazard stall for two cycles: bubbles, then the held ADD exactly once
    p0 = pops;
    instruction = I_ADD; in_valid = 1'b1; hazard = 1'b1;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
    #1 check("hz_in_ready", in_ready, 1'b0);
    tick();
    check("hz_bubble1", out_valid, 1'b0);
    tick();
    check("hz_bubble2", out_valid, 1'b0);
    hazard = 1'b0;
    #1 check("hz_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("hz_emit", out_valid, 1'b1);
    tick();
    check("hz_once_valid", out_valid, 1'b0);
    check("hz_once", pops - p0, 1);

    // Back-pressure: outputs frozen while out_ready is low
    instruction = I_MOV; in_valid = 1'b1;
    push(I_MOV, 4'h1, 1, 0, 0, 0, 0, 4'd4, 32'd0, 32'd6);
    tick();
    out_ready = 1'b0; instruction = I_EOR;
    #1 check("bp_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp_valid", out_valid, 1'b1);
      check("bp_cmd", Exe_CMD, 4'h1);
      check("bp_dest", Dest, 4'd4);
      check("bp_rm", Value_Rm, 32'd6);
    end
    out_ready = 1'b1;
    #1 check("bp_resume_ready", in_ready, 1'b1);
    push(I_EOR, 4'h8, 1, 0, 0, 0, 0, 4'd5, 32'd8, 32'd9);
    tick();
    in_valid = 1'b0;
    check("bp_next_cmd", Exe_CMD, 4'h8);
    tick();

    // Flush with valid output pending and hazard asserted: word dropped
    instruction = I_ADD; in_valid = 1'b1;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
    tick();
    instruction = I_SUBEQ; SR = 4'b0100; hazard = 1'b1; flush = 1'b1;
    #1 check("fl_in_ready", in_ready, 1'b1);
    tick();
    check("fl_valid", out_valid, 1'b0);
    flush = 1'b0; hazard = 1'b0; in_valid = 1'b0; SR = 4'b0000;
    tick();
    check("fl_dropped", out_valid, 1'b0);

    // Write-back in the capture cycle of a reader
    instruction = I_ADD; in_valid = 1'b1;
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h0000DEAD;
`ifdef ID_WB_BYPASS_EN
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'h0000DEAD, 32'd3);
`else
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
`endif
    tick();
    wb_en = 1'b0;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'h0000DEAD, 32'd3);
    tick();
    in_valid = 1'b0;
    tick();

    // Reset mid-operation clears outputs and reloads register contents
    instruction = I_ADD; in_valid = 1'b1;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'h0000DEAD, 32'd3);
    tick();
    in_valid = 1'b0;
    check("mr_valid_before", out_valid, 1'b1);
    #5 rst = 1'b0;
    #1 check("mr_valid", out_valid, 1'b0);
    check("mr_cmd", Exe_CMD, 4'h0);
    check("mr_rn", Value_Rn, 32'h0);
    check("mr_wb", WB_En, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    instruction = I_ADD; in_valid = 1'b1;
    push(I_ADD, 4'h2, 1, 0, 0, 0, 0, 4'd1, 32'd2, 32'd3);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
